// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that lets NUM_REQ requesters share a
// single UART transmitter. One byte is granted at a time. The block raises
// tx_en_o to start the frame, waits for the transmitter to go busy (with a
// timeout), then waits for the frame to complete.
//
// Ports
//   clk_i        clock; all state changes on its rising edge
//   arst_i       asynchronous reset, active low
//   req_valid_i  per-requester "byte pending" flags
//   req_data_i   per-requester bytes, requester k at [k*DATA_AMOUNT +: DATA_AMOUNT]
//   req_ack_o    one-hot, one-cycle acceptance pulse
//   tx_en_o      start request to the transmitter
//   tx_data_o    byte presented to the transmitter
//   tx_ready_i   transmitter idle (1) / frame in progress (0)
//   grant_id_o   index of the requester being served
//   busy_o       high whenever the FSM is not idle
//   done_o       one-cycle pulse when the served frame completes
//   err_o        one-cycle pulse when the transmitter never went busy
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned DATA_AMOUNT   = 8,
  parameter int unsigned START_TIMEOUT = 16
) (
  input  logic                             clk_i,
  input  logic                             arst_i,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  input  logic [NUM_REQ*DATA_AMOUNT-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]               req_ack_o,
  output logic                             tx_en_o,
  output logic [DATA_AMOUNT-1:0]           tx_data_o,
  input  logic                             tx_ready_i,
  output logic [$clog2(NUM_REQ)-1:0]       grant_id_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             err_o
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic                   tx_en_q, tx_en_d;
  logic [DATA_AMOUNT-1:0] data_q, data_d;
  logic [ID_W-1:0]        grant_q, grant_d;
  logic [ID_W-1:0]        last_q, last_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  // Round-robin search, starting one past the last grant and wrapping.
  // cand_c has one extra bit so last+i never overflows before the wrap.
  logic            win_found_c;
  logic [ID_W-1:0] win_idx_c;
  logic [ID_W:0]   cand_c;

  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = '0;
    cand_c      = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand_c = {1'b0, last_q} + (ID_W+1)'(i);
      if (cand_c >= (ID_W+1)'(NUM_REQ)) begin
        cand_c = cand_c - (ID_W+1)'(NUM_REQ);
      end
      if (!win_found_c && req_valid_i[cand_c[ID_W-1:0]]) begin
        win_found_c = 1'b1;
        win_idx_c   = cand_c[ID_W-1:0];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    ack_d   = '0;
    tx_en_d = tx_en_q;
    data_d  = data_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_en_d = 1'b0;
        cnt_d   = '0;
        if (tx_ready_i && win_found_c) begin
          data_d           = req_data_i[win_idx_c*DATA_AMOUNT +: DATA_AMOUNT];
          grant_d          = win_idx_c;
          last_d           = win_idx_c;
          ack_d[win_idx_c] = 1'b1;
          tx_en_d          = 1'b1;
          state_d          = ST_START;
        end
      end

      ST_START: begin
        tx_en_d = 1'b1;
        state_d = ST_WAIT_BUSY;
      end

      // tx_en is held until the transmitter reacts; START plus
      // START_TIMEOUT cycles here give START_TIMEOUT+1 cycles of tx_en.
      ST_WAIT_BUSY: begin
        tx_en_d = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (!tx_ready_i) begin
          tx_en_d = 1'b0;
          cnt_d   = '0;
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          tx_en_d = 1'b0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end

      ST_WAIT_DONE: begin
        tx_en_d = 1'b0;
        if (tx_ready_i) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        tx_en_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset gives requester 0 first priority.
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q <= ST_IDLE;
      ack_q   <= '0;
      tx_en_q <= 1'b0;
      data_q  <= '0;
      grant_q <= '0;
      last_q  <= ID_W'(NUM_REQ - 1);
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      tx_en_q <= tx_en_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign req_ack_o  = ack_q;
  assign tx_en_o    = tx_en_q;
  assign tx_data_o  = data_q;
  assign grant_id_o = grant_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural transmitter model and
// a scoreboard of expected grants (id, byte).
module tb_uart_tx_arbiter;

  localparam int unsigned NR    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned TO    = 8;
  localparam int unsigned FRAME = 20;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic             clk_i = 1'b0;
  logic             arst_i;
  logic [NR-1:0]    req_valid_i;
  logic [NR*DW-1:0] req_data_i;
  logic [NR-1:0]    req_ack_o;
  logic             tx_en_o;
  logic [DW-1:0]    tx_data_o;
  logic             tx_ready_i;
  logic [1:0]       grant_id_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;

  uart_tx_arbiter #(
    .NUM_REQ      (NR),
    .DATA_AMOUNT  (DW),
    .START_TIMEOUT(TO)
  ) dut (
    .clk_i      (clk_i),
    .arst_i     (arst_i),
    .req_valid_i(req_valid_i),
    .req_data_i (req_data_i),
    .req_ack_o  (req_ack_o),
    .tx_en_o    (tx_en_o),
    .tx_data_o  (tx_data_o),
    .tx_ready_i (tx_ready_i),
    .grant_id_o (grant_id_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  exp_t exp_q[$];
  exp_t cur;
  int   ack_cyc  = 0;
  int   done_cyc = 0;

  // Transmitter model: goes busy for FRAME cycles when started.
  bit         stuck       = 1'b0;
  bit         hold_low    = 1'b0;
  bit         model_ready = 1'b1;
  bit         m_busy      = 1'b0;
  int         m_cnt       = 0;
  logic [7:0] last_tx     = '0;

  assign tx_ready_i = stuck | (model_ready & ~hold_low);

  always @(negedge clk_i) begin
    if (m_busy) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_busy      = 1'b0;
        model_ready = 1'b1;
      end
    end else if (tx_en_o && tx_ready_i && !stuck) begin
      m_busy      = 1'b1;
      model_ready = 1'b0;
      m_cnt       = FRAME;
      last_tx     = tx_data_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] d);
    exp_t e;
    e.id   = id;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    arst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_ack",   32'(req_ack_o),  32'd0);
    chk("rst_tx_en", 32'(tx_en_o),    32'd0);
    chk("rst_data",  32'(tx_data_o),  32'd0);
    chk("rst_grant", 32'(grant_id_o), 32'd0);
    chk("rst_busy",  32'(busy_o),     32'd0);
    chk("rst_done",  32'(done_o),     32'd0);
    chk("rst_err",   32'(err_o),      32'd0);
    arst_i = 1'b1;
  endtask

  // Waits for an acknowledge and checks it against the scoreboard head.
  task automatic wait_grant();
    bit got = 1'b0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk_i);
      if (req_ack_o != '0) got = 1'b1;
    end
    chk("ack_seen", 32'(got), 32'd1);
    if (got) begin
      ack_cyc = cyc;
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        cur = exp_q.pop_front();
        chk("ack_onehot", 32'(req_ack_o),  32'(1) << cur.id);
        chk("grant_id",   32'(grant_id_o), 32'(cur.id));
        chk("tx_data",    32'(tx_data_o),  32'(cur.data));
        chk("start_en",   32'(tx_en_o),    32'd1);
        chk("start_busy", 32'(busy_o),     32'd1);
      end
    end
  endtask

  // Follows the frame to done_o, or to err_o when a timeout is expected.
  task automatic wait_end(input bit to);
    if (!to) begin
      bit got     = 1'b0;
      bit saw_err = 1'b0;
      for (int n = 0; n < 400 && !got; n++) begin
        @(negedge clk_i);
        if (n == 0) chk("ack_one_cycle", 32'(req_ack_o), 32'd0);
        if (err_o) saw_err = 1'b1;
        if (done_o) got = 1'b1;
      end
      done_cyc = cyc;
      chk("done_seen",   32'(got),        32'd1);
      chk("no_err",      32'(saw_err),    32'd0);
      chk("done_busy",   32'(busy_o),     32'd0);
      chk("data_held",   32'(tx_data_o),  32'(cur.data));
      chk("grant_held",  32'(grant_id_o), 32'(cur.id));
      chk("byte_on_line", 32'(last_tx),   32'(cur.data));
    end else begin
      int en_cnt = 1;
      for (int n = 0; n < 100; n++) begin
        @(negedge clk_i);
        if (!tx_en_o) break;
        en_cnt++;
      end
      chk("timeout_en_cycles", 32'(en_cnt), 32'(TO + 1));
      chk("timeout_err",       32'(err_o),  32'd1);
      chk("timeout_busy",      32'(busy_o), 32'd0);
      chk("timeout_no_done",   32'(done_o), 32'd0);
    end
  endtask

  initial begin
    int  rel_cyc;
    bit  saw_done;
    arst_i      = 1'b0;
    req_valid_i = '0;
    req_data_i  = '0;

    do_reset();

    // Single requester 2; its inputs change after acceptance.
    req_data_i[23:16] = 8'h72;
    req_valid_i       = 4'b0100;
    push(2'd2, 8'h72);
    wait_grant();
    req_valid_i = '0;
    req_data_i  = '1;
    wait_end(1'b0);

    // All requesters valid from reset: strictly cyclic 0,1,2,3,0.
    do_reset();
    req_data_i  = 32'hA3A2A1A0;
    req_valid_i = 4'b1111;
    for (int k = 0; k < 5; k++) push(2'(k), 8'hA0 + 8'(k % 4));
    for (int k = 0; k < 5; k++) begin
      wait_grant();
      if (k == 4) req_valid_i = '0;
      wait_end(1'b0);
    end

    // Grant 1, then 0011 pending: search starts at 2 and wraps to 0.
    req_data_i  = 32'hB3B2B1B0;
    req_valid_i = 4'b0010;
    push(2'd1, 8'hB1);
    wait_grant();
    req_valid_i = 4'b0011;
    push(2'd0, 8'hB0);
    wait_end(1'b0);
    wait_grant();
    req_valid_i = '0;
    wait_end(1'b0);

    // Single requester held: back-to-back with one idle cycle between.
    req_valid_i = 4'b0001;
    push(2'd0, 8'hB0);
    push(2'd0, 8'hB0);
    wait_grant();
    wait_end(1'b0);
    wait_grant();
    chk("b2b_gap", 32'(ack_cyc - done_cyc), 32'd1);
    req_valid_i = '0;
    wait_end(1'b0);

    // Transmitter not ready in IDLE: grant waits, then lands on that edge.
    hold_low    = 1'b1;
    req_data_i  = 32'hC35AC1C0;
    req_valid_i = 4'b0100;
    push(2'd2, 8'h5A);
    repeat (5) begin
      @(negedge clk_i);
      chk("no_ack_not_ready", 32'(req_ack_o), 32'd0);
    end
    rel_cyc  = cyc;
    hold_low = 1'b0;
    wait_grant();
    chk("ready_grant_latency", 32'(ack_cyc - rel_cyc), 32'd1);
    req_valid_i = '0;
    wait_end(1'b0);

    // Stuck-ready transmitter: timeout, then the next requester is served.
    stuck       = 1'b1;
    req_data_i  = 32'hD3D2D1D0;
    req_valid_i = 4'b1001;
    push(2'd3, 8'hD3);
    push(2'd0, 8'hD0);
    wait_grant();
    wait_end(1'b1);
    stuck = 1'b0;
    wait_grant();
    req_valid_i = '0;
    wait_end(1'b0);

    // Reset during WAIT_DONE aborts at once, no done_o afterwards.
    req_data_i  = 32'hE3E2E1E0;
    req_valid_i = 4'b0100;
    push(2'd2, 8'hE2);
    wait_grant();
    req_valid_i = '0;
    repeat (5) @(negedge clk_i);
    chk("wd_busy",  32'(busy_o),  32'd1);
    chk("wd_tx_en", 32'(tx_en_o), 32'd0);
    #2 arst_i = 1'b0;
    #1;
    chk("abort_tx_en", 32'(tx_en_o),    32'd0);
    chk("abort_busy",  32'(busy_o),     32'd0);
    chk("abort_grant", 32'(grant_id_o), 32'd0);
    chk("abort_data",  32'(tx_data_o),  32'd0);
    saw_done = 1'b0;
    repeat (30) begin
      @(negedge clk_i);
      if (done_o || req_ack_o != '0) saw_done = 1'b1;
    end
    chk("abort_no_done_no_ack", 32'(saw_done), 32'd0);
    req_valid_i = 4'b0001;
    push(2'd0, 8'hE0);
    arst_i = 1'b1;
    wait_grant();
    req_valid_i = '0;
    wait_end(1'b0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
